// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Detects load-use hazards and EX redirects, drives stall/flush/bubble,
// runs the debug RUN/HALT/STEP machine and counts load-use stall cycles.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_redirect,
  input  logic [31:0]      pc,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  output logic             stall,
  output logic             clean_n,
  output logic             id_ex_bubble,
  output logic             breakpoint,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rearm_q, rearm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu;
  logic bp_hit;
  logic frozen;
  logic cnt_en;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Zero-latency hazard terms; register 0 never produces a hazard.
  always_comb begin
    lu     = ex_memread && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // Match is masked for the first RUN cycle after a resume.
    bp_hit = bp_en && (pc == bp_addr) && !rearm_q;
    frozen = (state_q == S_HALT);
    cnt_en = !frozen && !ex_redirect && lu;
  end

  // Debug FSM next state and breakpoint re-arm flag.
  always_comb begin
    state_d = state_q;
    rearm_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (dbg_halt || bp_hit) state_d = S_HALT;
      end
      S_HALT: begin
        if (dbg_step) begin
          state_d = S_STEP;
        end else if (dbg_resume) begin
          state_d = S_RUN;
          rearm_d = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Pipeline control outputs: frozen forces everything inactive, else redirect beats load-use.
  always_comb begin
    stall        = 1'b0;
    clean_n      = 1'b1;
    id_ex_bubble = 1'b0;
    if (!frozen) begin
      if (ex_redirect) begin
        clean_n      = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (lu) begin
        stall        = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
    breakpoint   = frozen;
    halted       = (state_q != S_RUN);
    stall_cycles = cnt_q;
  end

  // Stall counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_en) cnt_d = sat_inc(cnt_q);
  end

  // State, re-arm flag and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      rearm_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic compared against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, ex_redirect;
  logic [31:0]      pc, bp_addr;
  logic             bp_en, dbg_halt, dbg_step, dbg_resume;
  logic             stall, clean_n, id_ex_bubble, breakpoint, halted;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .ex_redirect  (ex_redirect),
    .pc           (pc),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .dbg_halt     (dbg_halt),
    .dbg_step     (dbg_step),
    .dbg_resume   (dbg_resume),
    .stall        (stall),
    .clean_n      (clean_n),
    .id_ex_bubble (id_ex_bubble),
    .breakpoint   (breakpoint),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Behavioural model: frozen = debugger holds the pipe, stepping = the one
  // released cycle, skip_bp = first cycle after resume ignores the PC match.
  bit m_frozen, m_stepping, m_skip_bp;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; ex_redirect = 1'b0;
    dbg_halt = 1'b0; dbg_step = 1'b0; dbg_resume = 1'b0;
  endtask

  task automatic model_reset();
    m_frozen = 0; m_stepping = 0; m_skip_bp = 0; m_cnt = 0;
  endtask

  // One clock cycle: inputs already driven; check outputs mid-cycle,
  // advance the model across the edge, then check the counter.
  task automatic cycle(input string tag);
    bit lu;
    bit e_stall, e_clean_n, e_bub;
    bit n_frozen, n_stepping, n_skip;
    #1;
    lu = ex_memread && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e_stall = 0; e_clean_n = 1; e_bub = 0;
    if (!m_frozen) begin
      if (ex_redirect) begin
        e_clean_n = 0; e_bub = 1;
      end else if (lu) begin
        e_stall = 1; e_bub = 1;
      end
    end
    chk({tag, ".stall"},        32'(stall),        32'(e_stall));
    chk({tag, ".clean_n"},      32'(clean_n),      32'(e_clean_n));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
    chk({tag, ".breakpoint"},   32'(breakpoint),   32'(m_frozen));
    chk({tag, ".halted"},       32'(halted),       32'(m_frozen || m_stepping));

    if (!m_frozen && !ex_redirect && lu && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    n_frozen = m_frozen; n_stepping = 0; n_skip = 0;
    if (m_stepping) begin
      n_frozen = 1;
    end else if (m_frozen) begin
      if (dbg_step) begin
        n_frozen = 0; n_stepping = 1;
      end else if (dbg_resume) begin
        n_frozen = 0; n_skip = 1;
      end
    end else if (dbg_halt || (bp_en && pc == bp_addr && !m_skip_bp)) begin
      n_frozen = 1;
    end

    @(posedge clk);
    #1;
    m_frozen = n_frozen; m_stepping = n_stepping; m_skip_bp = n_skip;
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_cnt));
    dbg_halt = 1'b0; dbg_step = 1'b0; dbg_resume = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst.stall",        32'(stall),        32'd0);
    chk("rst.clean_n",      32'(clean_n),      32'd1);
    chk("rst.id_ex_bubble", 32'(id_ex_bubble), 32'd0);
    chk("rst.breakpoint",   32'(breakpoint),   32'd0);
    chk("rst.halted",       32'(halted),       32'd0);
    chk("rst.stall_cycles", 32'(stall_cycles), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    pc = 32'h0; bp_en = 1'b0; bp_addr = 32'h40;
    rst = 1'b0;
    do_reset();

    // Load-use on rs: one-cycle stall, counter 0 -> 1.
    ex_memread = 1; ex_rt = 8; id_rs = 8;
    cycle("lu_rs");
    ex_memread = 0;
    cycle("lu_rs_after");

    // Register 0 never hazards.
    ex_memread = 1; ex_rt = 0; id_rs = 0;
    cycle("lu_r0");
    // rt mismatch on rs, and rt not used as a source.
    ex_rt = 9; id_rs = 8; id_rt = 9; id_uses_rt = 0;
    cycle("lu_rt_unused");
    // Same but rt is used: hazard.
    id_uses_rt = 1;
    cycle("lu_rt_used");
    idle_inputs();
    cycle("idle");

    // Redirect overrides load-use and does not count.
    ex_memread = 1; ex_rt = 8; id_rs = 8; ex_redirect = 1;
    cycle("redir_lu");
    idle_inputs();
    cycle("idle2");

    // Saturation: 20 load-use stalls with a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      ex_memread = 1; ex_rt = 5'(1 + (i % 30)); id_rs = ex_rt;
      cycle("sat_lu");
      ex_memread = 0;
      cycle("sat_gap");
    end
    chk("sat.hold", 32'(stall_cycles), 32'(CNT_MAX));

    // PC breakpoint at 0x40, single step, resume without re-halt.
    bp_en = 1; bp_addr = 32'h40; pc = 32'h3c;
    cycle("bp_pre");
    pc = 32'h40;
    cycle("bp_hit");
    chk("bp.frozen", 32'(breakpoint), 32'd1);
    ex_memread = 1; ex_rt = 3; id_rs = 3;
    cycle("bp_halt_hazard_masked");
    idle_inputs();
    dbg_halt = 1; dbg_resume = 0;
    cycle("halt_ignores_halt");
    dbg_step = 1;
    cycle("step_req");
    chk("step.open", 32'(breakpoint), 32'd0);
    cycle("step_cycle");
    chk("step.closed", 32'(breakpoint), 32'd1);
    dbg_step = 1; dbg_resume = 1;
    cycle("step_beats_resume");
    cycle("step2_cycle");
    dbg_resume = 1;
    cycle("resume_req");
    chk("resume.run", 32'(halted), 32'd0);
    cycle("resume_no_rehalt");
    pc = 32'h44;
    cycle("resume_next");
    chk("resume.stays_run", 32'(halted), 32'd0);

    // Reset while halted: outputs drop immediately.
    dbg_halt = 1;
    cycle("halt_ext");
    chk("halt_ext.halted", 32'(halted), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.halted",       32'(halted),       32'd0);
    chk("rst_mid.breakpoint",   32'(breakpoint),   32'd0);
    chk("rst_mid.stall_cycles", 32'(stall_cycles), 32'd0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_memread  = ($urandom_range(0, 2) != 0);
      ex_rt       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 5) == 0);
      bp_en       = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       pc = 32'h3c;
        1:       pc = 32'h40;
        2:       pc = 32'h44;
        default: pc = $urandom;
      endcase
      dbg_halt    = ($urandom_range(0, 15) == 0);
      dbg_step    = ($urandom_range(0, 3) == 0);
      dbg_resume  = ($urandom_range(0, 4) == 0);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
